// File: rtl/icache_tag_array_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_tag_array_pkg
// Description : Shared instruction-cache types. Holds the tag-array entry
//               record and the control-state encoding used by the tag array
//               and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_tag_array_pkg;

    // Widest tag any configuration may store. The entry record has a fixed
    // width. Narrower tags are zero-extended on write and compared at full
    // width, so the upper bits always compare equal.
    localparam int unsigned c_TAG_MAX_W = 64;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_FLUSH = 2'd2
    } icache_state_e;

    typedef struct packed {
        logic                   valid;
        logic [c_TAG_MAX_W-1:0] tag;
    } icache_tag_entry_t;

endpackage
`default_nettype wire

// File: rtl/icache_victim_sel.sv
`default_nettype none
// ============================================================================
// Module      : icache_victim_sel
// Description : Per-set replacement choice. It picks the lowest invalid way of
//               the looked-up set. When every way is valid, it returns that
//               set's round-robin pointer. Each refill advances the pointer of
//               the refilled set.
// Ports       : i_clk, i_rst_n    - clock, synchronous active-low reset
//               i_lookup_idx       - set being looked up
//               i_set_valid        - valid bits of that set
//               i_adv, i_adv_idx   - refill strobe and refilled set
//               o_victim           - way to refill (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module icache_victim_sel #(
    parameter  int unsigned NUM_SETS = 64,
    parameter  int unsigned NUM_WAYS = 4,
    localparam int unsigned c_IDX_W  = $clog2(NUM_SETS),
    localparam int unsigned c_WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [c_IDX_W-1:0] i_lookup_idx,
    input  logic [NUM_WAYS-1:0] i_set_valid,
    input  logic               i_adv,
    input  logic [c_IDX_W-1:0] i_adv_idx,
    output logic [c_WAY_W-1:0] o_victim
);

    logic [c_WAY_W-1:0] r_ptr [NUM_SETS];

    // The explicit wrap keeps NUM_WAYS=1 at way 0 even though the pointer
    // is one bit wide.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                r_ptr[s] <= '0;
            end
        end else if (i_adv) begin
            r_ptr[i_adv_idx] <= (r_ptr[i_adv_idx] == c_WAY_W'(NUM_WAYS - 1))
                              ? '0 : r_ptr[i_adv_idx] + c_WAY_W'(1);
        end
    end

    // The loop scans from high to low, so the lowest invalid way wins.
    always_comb begin
        o_victim = r_ptr[i_lookup_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!i_set_valid[w]) begin
                o_victim = c_WAY_W'(w);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/icache_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_tag_array
// Description : Set-associative instruction-cache tag array held in flops.
//               It answers a registered one-cycle lookup (hit, hit way,
//               victim way) and has one refill write port. The valid bits are
//               cleared one set per cycle after reset and on a flush.
// Ports       : i_clk, i_rst_n               - clock, sync active-low reset
//               i_stall, i_flush             - hold results / invalidate all
//               i_pc, i_read, o_avail        - lookup request and acceptance
//               o_valid, o_pc, o_hit,
//               o_hit_way, o_victim_way      - registered lookup result
//               i_refill_valid, i_refill_pc,
//               i_refill_way                 - tag write port
// Revision    : 1.0 - initial release
// ============================================================================
module icache_tag_array
    import icache_tag_array_pkg::*;
#(
    parameter  int unsigned NUM_SETS    = 64,
    parameter  int unsigned NUM_WAYS    = 4,
    parameter  int unsigned LINE_BYTES  = 64,
    parameter  int unsigned VADDR_WIDTH = 32,
    localparam int unsigned c_WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic [VADDR_WIDTH-1:0] i_pc,
    input  logic                   i_read,
    output logic                   o_avail,
    output logic                   o_valid,
    output logic [VADDR_WIDTH-1:0] o_pc,
    output logic                   o_hit,
    output logic [c_WAY_W-1:0]     o_hit_way,
    output logic [c_WAY_W-1:0]     o_victim_way,
    input  logic                   i_refill_valid,
    input  logic [VADDR_WIDTH-1:0] i_refill_pc,
    input  logic [c_WAY_W-1:0]     i_refill_way
);

    localparam int unsigned c_OFS_W = $clog2(LINE_BYTES);
    localparam int unsigned c_IDX_W = $clog2(NUM_SETS);
    localparam int unsigned c_TAG_W = VADDR_WIDTH - c_IDX_W - c_OFS_W;

    icache_state_e        r_state, w_state_nxt;
    logic [c_IDX_W-1:0]   r_walk_idx, w_walk_idx_nxt;
    icache_tag_entry_t    r_entry [NUM_SETS][NUM_WAYS];

    logic [c_IDX_W-1:0]   w_lu_idx, w_rf_idx;
    logic [c_TAG_W-1:0]   w_lu_tag, w_rf_tag;
    logic [NUM_WAYS-1:0]  w_set_valid, w_match;
    logic                 w_walking, w_refill_we, w_accept, w_hit;
    logic [c_WAY_W-1:0]   w_hit_way, w_victim;

    logic                   r_valid, r_hit;
    logic [VADDR_WIDTH-1:0] r_pc;
    logic [c_WAY_W-1:0]     r_hit_way, r_victim_way;

    // The refill offset bits do not select anything.
    logic w_unused_refill_ofs;
    assign w_unused_refill_ofs = ^i_refill_pc[c_OFS_W-1:0];

    assign w_lu_idx = i_pc[c_OFS_W +: c_IDX_W];
    assign w_lu_tag = i_pc[VADDR_WIDTH-1 -: c_TAG_W];
    assign w_rf_idx = i_refill_pc[c_OFS_W +: c_IDX_W];
    assign w_rf_tag = i_refill_pc[VADDR_WIDTH-1 -: c_TAG_W];

    assign w_walking   = (r_state == ST_INIT) || (r_state == ST_FLUSH);
    assign w_refill_we = i_refill_valid && (r_state == ST_READY);
    // Reset is folded in so acceptance is low while reset is held, even
    // before the state register has seen its first reset edge.
    assign o_avail     = i_rst_n && (r_state == ST_READY) && !i_stall
                       && !i_flush && !i_refill_valid;
    assign w_accept    = o_avail && i_read;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= ST_INIT;
            r_walk_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_walk_idx <= w_walk_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_walk_idx_nxt = r_walk_idx;
        if (i_flush) begin
            w_state_nxt    = ST_FLUSH;
            w_walk_idx_nxt = '0;
        end else begin
            case (r_state)
                ST_INIT, ST_FLUSH: begin
                    if (r_walk_idx == c_IDX_W'(NUM_SETS - 1)) begin
                        w_state_nxt    = ST_READY;
                        w_walk_idx_nxt = '0;
                    end else begin
                        w_walk_idx_nxt = r_walk_idx + c_IDX_W'(1);
                    end
                end
                ST_READY: ;
                default: begin
                    w_state_nxt    = ST_INIT;
                    w_walk_idx_nxt = '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------- tag array
    // There is no reset on the array. The INIT walk clears every valid bit
    // before any lookup can be accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            if (w_walking) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    r_entry[r_walk_idx][w].valid <= 1'b0;
                end
            end else if (w_refill_we) begin
                r_entry[w_rf_idx][i_refill_way].valid <= 1'b1;
                r_entry[w_rf_idx][i_refill_way].tag   <= c_TAG_MAX_W'(w_rf_tag);
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
            assign w_set_valid[g] = r_entry[w_lu_idx][g].valid;
            assign w_match[g]     = r_entry[w_lu_idx][g].valid
                                 && (r_entry[w_lu_idx][g].tag == c_TAG_MAX_W'(w_lu_tag));
        end
    endgenerate

    // If several ways match, the lowest way is reported.
    always_comb begin
        w_hit     = |w_match;
        w_hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (w_match[w]) begin
                w_hit_way = c_WAY_W'(w);
            end
        end
    end

    icache_victim_sel #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_victim_sel (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_lookup_idx (w_lu_idx),
        .i_set_valid  (w_set_valid),
        .i_adv        (w_refill_we),
        .i_adv_idx    (w_rf_idx),
        .o_victim     (w_victim)
    );

    // -------------------------------------------------- result register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_hit        <= 1'b0;
            r_hit_way    <= '0;
            r_victim_way <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_pc         <= i_pc;
                r_hit        <= w_hit;
                r_hit_way    <= w_hit_way;
                r_victim_way <= w_victim;
            end
        end
    end

    assign o_valid      = r_valid;
    assign o_pc         = r_pc;
    assign o_hit        = r_hit;
    assign o_hit_way    = r_hit_way;
    assign o_victim_way = r_victim_way;

endmodule
`default_nettype wire

// File: tb/tb_icache_tag_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_tag_array
// Description : Self-checking bench for icache_tag_array (64 sets, 4 ways,
//               64-byte lines, 32-bit PC). It runs directed scenarios and
//               then random traffic. Every cycle is compared against a
//               behavioural cache model that keeps its state in plain arrays.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_tag_array;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_read = 1'b0;
    logic        i_refill_valid = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_refill_pc = '0;
    logic [1:0]  i_refill_way = '0;
    logic        o_avail, o_valid, o_hit;
    logic [31:0] o_pc;
    logic [1:0]  o_hit_way, o_victim_way;

    icache_tag_array #(
        .NUM_SETS    (64),
        .NUM_WAYS    (4),
        .LINE_BYTES  (64),
        .VADDR_WIDTH (32)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_stall        (i_stall),
        .i_flush        (i_flush),
        .i_pc           (i_pc),
        .i_read         (i_read),
        .o_avail        (o_avail),
        .o_valid        (o_valid),
        .o_pc           (o_pc),
        .o_hit          (o_hit),
        .o_hit_way      (o_hit_way),
        .o_victim_way   (o_victim_way),
        .i_refill_valid (i_refill_valid),
        .i_refill_pc    (i_refill_pc),
        .i_refill_way   (i_refill_way)
    );

    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per-line valid/tag, per-set round-robin pointer, and
    // the number of cycles left before the array accepts lookups.
    bit          m_valid [64][4];
    logic [19:0] m_tag   [64][4];
    int          m_rr    [64];
    int          m_busy = 64;
    bit          e_valid = 0, e_hit = 0;
    int          e_hw = 0, e_vw = 0;
    logic [31:0] e_pc = '0;
    bit          avail_known = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check o_avail mid-cycle, advance the
    // model at the edge, then check the registered results.
    task automatic step(input bit rst_n, input bit rd, input logic [31:0] pc,
                        input bit stall, input bit flush, input bit rf,
                        input logic [31:0] rpc, input int rway);
        bit e_av, acc, l_hit;
        int set, rset, l_hw, l_vw;
        i_rst_n = rst_n; i_read = rd; i_pc = pc; i_stall = stall; i_flush = flush;
        i_refill_valid = rf; i_refill_pc = rpc; i_refill_way = 2'(rway);
        #4;
        e_av = rst_n && (m_busy == 0) && !stall && !flush && !rf;
        if (avail_known) check("avail", {31'd0, o_avail}, {31'd0, e_av});
        @(posedge i_clk);
        if (!rst_n) begin
            m_busy = 64;
            for (int s = 0; s < 64; s++) m_rr[s] = 0;
            e_valid = 0; e_hit = 0; e_hw = 0; e_vw = 0; e_pc = '0;
        end else begin
            acc = e_av && rd;
            set = int'(pc[11:6]);
            l_hit = 0; l_hw = 0; l_vw = -1;
            for (int w = 0; w < 4; w++) begin
                if (!l_hit && m_valid[set][w] && m_tag[set][w] == pc[31:12]) begin
                    l_hit = 1; l_hw = w;
                end
                if (l_vw < 0 && !m_valid[set][w]) l_vw = w;
            end
            if (l_vw < 0) l_vw = m_rr[set];
            if (flush) e_valid = 0;
            else if (!stall) begin
                e_valid = acc;
                if (acc) begin e_pc = pc; e_hit = l_hit; e_hw = l_hw; e_vw = l_vw; end
            end
            if (rf && m_busy == 0) begin
                rset = int'(rpc[11:6]);
                m_valid[rset][rway] = 1;
                m_tag[rset][rway]   = rpc[31:12];
                m_rr[rset]          = (m_rr[rset] + 1) % 4;
            end
            if (flush) m_busy = 64;
            else if (m_busy > 0) begin
                for (int w = 0; w < 4; w++) m_valid[64 - m_busy][w] = 0;
                m_busy--;
            end
        end
        #1;
        avail_known = 1;
        check("valid", {31'd0, o_valid}, {31'd0, e_valid});
        if (!rst_n || e_valid) begin
            check("pc", o_pc, e_pc);
            check("hit", {31'd0, o_hit}, {31'd0, e_hit});
            check("hit_way", {30'd0, o_hit_way}, 32'(e_hw));
            check("victim_way", {30'd0, o_victim_way}, 32'(e_vw));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, '0, 0, 0, 0, '0, 0);
    endtask
    task automatic rd(input logic [31:0] pc);
        step(1, 1, pc, 0, 0, 0, '0, 0);
    endtask
    task automatic refill(input logic [31:0] pc, input int way);
        step(1, 0, '0, 0, 0, 1, pc, way);
    endtask
    task automatic do_reset();
        for (int k = 0; k < 3; k++) step(0, 0, '0, 0, 0, 0, '0, 0);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] p;
        p = {20'($urandom_range(0, 5)), 6'($urandom_range(0, 3)), 6'($urandom)};
        return p;
    endfunction

    initial begin
        // Reset, 64-cycle init walk, first lookup misses with victim way 0.
        do_reset();
        idle(64);
        rd(32'h0000_1000);
        check("r33_valid", {31'd0, o_valid}, 32'd1);
        check("r33_hit", {31'd0, o_hit}, 32'd0);
        check("r33_victim", {30'd0, o_victim_way}, 32'd0);

        // Refill, then a hit on the next cycle.
        refill(32'h0000_1040, 2);
        rd(32'h0000_1044);
        check("r34_hit", {31'd0, o_hit}, 32'd1);
        check("r34_way", {30'd0, o_hit_way}, 32'd2);
        check("r34_pc", o_pc, 32'h0000_1044);

        // Round-robin replacement after a full set, starting from fresh pointers.
        do_reset();
        idle(64);
        refill(32'h0000_0040, 0);
        refill(32'h0000_1040, 1);
        refill(32'h0000_2040, 2);
        refill(32'h0000_3040, 3);
        rd(32'h0000_4040);
        check("r35_miss", {31'd0, o_hit}, 32'd0);
        check("r35_victim0", {30'd0, o_victim_way}, 32'd0);
        refill(32'h0000_4040, 0);
        rd(32'h0000_5040);
        check("r35_victim1", {30'd0, o_victim_way}, 32'd1);

        // Stall holds a pending hit result; release without a read drops o_valid.
        rd(32'h0000_1040);
        for (int k = 0; k < 3; k++) step(1, 1, 32'h0000_2040, 1, 0, 0, '0, 0);
        check("r36_held_hit", {31'd0, o_hit}, 32'd1);
        check("r36_held_way", {30'd0, o_hit_way}, 32'd1);
        idle(1);
        check("r36_released", {31'd0, o_valid}, 32'd0);

        // A flush partway through a walk restarts it, and afterwards the line misses.
        step(1, 0, '0, 0, 1, 0, '0, 0);
        idle(30);
        step(1, 0, '0, 0, 1, 0, '0, 0);
        idle(64);
        rd(32'h0000_1040);
        check("r37_miss", {31'd0, o_hit}, 32'd0);

        // A refill and a read in the same cycle: the read is refused, the refill lands.
        step(1, 1, 32'h0000_7080, 0, 0, 1, 32'h0000_7080, 3);
        check("r38_no_valid", {31'd0, o_valid}, 32'd0);
        rd(32'h0000_7080);
        check("r38_hit", {31'd0, o_hit}, 32'd1);
        check("r38_way", {30'd0, o_hit_way}, 32'd3);

        // Reset during a refill and during a flush leaves nothing valid.
        step(0, 0, '0, 0, 0, 1, 32'h0000_90C0, 1);
        step(1, 0, '0, 0, 0, 0, '0, 0);
        idle(10);
        step(1, 0, '0, 0, 1, 0, '0, 0);
        idle(5);
        do_reset();
        idle(64);
        rd(32'h0000_90C0);
        check("r29_miss", {31'd0, o_hit}, 32'd0);

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            step(($urandom_range(0, 499) != 0),
                 ($urandom_range(0, 3) != 0), rand_pc(),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 79) == 0),
                 ($urandom_range(0, 3) == 0), rand_pc(),
                 int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
